// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the IF/MEM single-port SRAM arbiter: in-flight read tags
// and the next-tag selection used by the response stage.
package sram_port_arbiter_pkg;

    localparam int CONFLICT_W = 32;

    typedef enum logic [1:0] {
        INFLIGHT_NONE    = 2'd0,
        INFLIGHT_INST_RD = 2'd1,
        INFLIGHT_DATA_RD = 2'd2
    } inflight_e;

    // Writes and idle cycles leave nothing to return next cycle.
    function automatic inflight_e inflight_next(input logic inst_gnt, input logic data_rd_gnt);
        if (inst_gnt) begin
            return INFLIGHT_INST_RD;
        end else if (data_rd_gnt) begin
            return INFLIGHT_DATA_RD;
        end
        return INFLIGHT_NONE;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the CPU's inst/data SRAM ports, the arbiter and the SRAM.
// master = CPU/SRAM side that drives requests and read data; slave = arbiter.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_gnt;
    logic              inst_rvalid;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic [BE_W-1:0]   data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;

    logic              cancel;

    logic              sram_en;
    logic [BE_W-1:0]   sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic [31:0]       conflict_cnt;

    modport master (
        output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
               cancel, sram_rdata,
        input  inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid,
               data_rdata, sram_en, sram_wen, sram_addr, sram_wdata, conflict_cnt
    );

    modport slave (
        input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
               cancel, sram_rdata,
        output inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid,
               data_rdata, sram_en, sram_wen, sram_addr, sram_wdata, conflict_cnt
    );

endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous-read SRAM port between IF reads and MEM reads/writes:
// one grant per cycle, tagged read returns one cycle later, bounded IF starvation.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               reset,
    sram_port_arbiter_if.slave bus
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic                  force_inst;
    logic                  inst_gnt_p0;
    logic                  data_gnt_p0;
    logic                  data_rd_p0;
    logic [ADDR_W-1:0]     sram_addr_p0;
    logic [DATA_W-1:0]     sram_wdata_p0;
    logic [BE_W-1:0]       sram_wen_p0;

    inflight_e             inflight_p1;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [CONFLICT_W-1:0] conflict_cnt;

    // ---- stage p0: same-cycle grant and SRAM port drive ----
    always_comb begin
        force_inst    = (starve_cnt == STARVE_W'(STARVE_MAX));
        inst_gnt_p0   = 1'b0;
        data_gnt_p0   = 1'b0;
        if (!reset) begin
            // A cancelled IF request cannot win, so MEM takes the slot even when IF is owed one.
            inst_gnt_p0 = bus.inst_req & ~bus.cancel & (~bus.data_req | force_inst);
            data_gnt_p0 = bus.data_req & ~inst_gnt_p0;
        end
        data_rd_p0    = data_gnt_p0 & (bus.data_wen == '0);
        sram_addr_p0  = data_gnt_p0 ? bus.data_addr : bus.inst_addr;
        sram_wdata_p0 = data_gnt_p0 ? bus.data_wdata : '0;
        sram_wen_p0   = data_gnt_p0 ? bus.data_wen : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_p1  <= INFLIGHT_NONE;
            starve_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            inflight_p1 <= inflight_next(inst_gnt_p0, data_rd_p0);

            if (inst_gnt_p0 || !bus.inst_req) begin
                starve_cnt <= '0;
            end else if (bus.data_req && data_gnt_p0 && !force_inst) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end

            if (bus.inst_req && bus.data_req) begin
                conflict_cnt <= conflict_cnt + CONFLICT_W'(1);
            end
        end
    end

    // ---- stage p1: tagged read response ----
    assign bus.inst_gnt     = inst_gnt_p0;
    assign bus.data_gnt     = data_gnt_p0;
    assign bus.sram_en      = inst_gnt_p0 | data_gnt_p0;
    assign bus.sram_addr    = sram_addr_p0;
    assign bus.sram_wdata   = sram_wdata_p0;
    assign bus.sram_wen     = sram_wen_p0;

    assign bus.inst_rvalid  = ~reset & (inflight_p1 == INFLIGHT_INST_RD) & ~bus.cancel;
    assign bus.data_rvalid  = ~reset & (inflight_p1 == INFLIGHT_DATA_RD);
    assign bus.inst_rdata   = bus.sram_rdata;
    assign bus.data_rdata   = bus.sram_rdata;
    assign bus.conflict_cnt = conflict_cnt;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios then random traffic, all
// outputs compared each cycle against a cycle-level reference model.
module tb_sram_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Reference model state
    int          waited_losses;   // consecutive cycles IF waited while MEM was served
    logic [31:0] conflicts_m;
    int          pending_kind;    // 0 none, 1 instruction read, 2 data read

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic obs_ig, obs_dg, obs_irv, obs_drv;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [3:0] wen,
                         input logic [31:0] da, input logic [31:0] wd,
                         input logic cc, input logic rst);
        logic        ig, dg, irv, drv;
        logic [31:0] rd;
        @(negedge clk);
        rd              = $urandom;
        reset           = rst;
        bus.inst_req    = ir;
        bus.inst_addr   = ia;
        bus.data_req    = dr;
        bus.data_wen    = wen;
        bus.data_addr   = da;
        bus.data_wdata  = wd;
        bus.cancel      = cc;
        bus.sram_rdata  = rd;

        if (rst) begin
            ig = 1'b0;
            dg = 1'b0;
        end else if (ir && dr && !cc) begin
            ig = (waited_losses == STARVE_MAX);
            dg = !ig;
        end else begin
            ig = ir && !cc;
            dg = dr;
        end
        irv = !rst && pending_kind == 1 && !cc;
        drv = !rst && pending_kind == 2;

        #1;
        obs_ig  = bus.inst_gnt;
        obs_dg  = bus.data_gnt;
        obs_irv = bus.inst_rvalid;
        obs_drv = bus.data_rvalid;
        check("inst_gnt", bus.inst_gnt, ig);
        check("data_gnt", bus.data_gnt, dg);
        check("sram_en", bus.sram_en, ig | dg);
        check("sram_wen", bus.sram_wen, dg ? wen : 4'b0000);
        if (ig || dg) check("sram_addr", bus.sram_addr, dg ? da : ia);
        if (dg) check("sram_wdata", bus.sram_wdata, wd);
        check("inst_rvalid", bus.inst_rvalid, irv);
        check("data_rvalid", bus.data_rvalid, drv);
        if (irv) check("inst_rdata", bus.inst_rdata, rd);
        if (drv) check("data_rdata", bus.data_rdata, rd);
        check("conflict_cnt", bus.conflict_cnt, conflicts_m);

        @(posedge clk);
        if (rst) begin
            waited_losses = 0;
            conflicts_m   = 32'd0;
            pending_kind  = 0;
        end else begin
            if (ir && dr) conflicts_m = conflicts_m + 32'd1;
            pending_kind = ig ? 1 : ((dg && wen == 4'b0000) ? 2 : 0);
            if (ig || !ir) waited_losses = 0;
            else if (dr && dg && waited_losses < STARVE_MAX) waited_losses = waited_losses + 1;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        waited_losses = 0;
        conflicts_m   = 32'd0;
        pending_kind  = 0;
        reset          = 1'b1;
        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_wen   = '0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.cancel     = 1'b0;
        bus.sram_rdata = '0;

        // Reset with both requesters active: nothing may be granted
        cycle(1'b1, 32'h1000, 1'b1, 4'b0000, 32'h2000, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h1000, 1'b1, 4'b0000, 32'h2000, 32'h0, 1'b0, 1'b1);
        check("reset_no_gnt", {obs_ig, obs_dg}, 2'b00);
        idle();
        check("reset_conflict_zero", bus.conflict_cnt, 32'd0);

        // IF-only fetch from the boot vector
        cycle(1'b1, 32'hBFC00000, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
        check("if_only_gnt", obs_ig, 1'b1);
        idle();
        check("if_only_rvalid", obs_irv, 1'b1);

        // Sustained conflict: D,D,D,D,I repeating
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h40 + 32'(i), 1'b1, 4'b0000, 32'h80 + 32'(i), 32'h0, 1'b0, 1'b0);
            check("conflict_order", obs_ig, (i % 5) == 4);
        end
        idle();

        // Partial store: no read return
        cycle(1'b0, 32'h0, 1'b1, 4'b0011, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0);
        check("store_gnt", obs_dg, 1'b1);
        idle();
        check("store_no_rvalid", obs_drv, 1'b0);

        // Cancel kills the in-flight IF read and blocks IF, data read still served
        cycle(1'b1, 32'h200, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h204, 1'b1, 4'b0000, 32'h300, 32'h0, 1'b1, 1'b0);
        check("cancel_irv", {obs_irv, obs_ig, obs_dg}, 3'b001);
        idle();
        check("cancel_data_rvalid", obs_drv, 1'b1);

        // Back-to-back I, D, I reads
        cycle(1'b1, 32'h400, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 4'b0000, 32'h500, 32'h0, 1'b0, 1'b0);
        check("b2b_1", {obs_irv, obs_drv}, 2'b10);
        cycle(1'b1, 32'h404, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
        check("b2b_2", {obs_irv, obs_drv}, 2'b01);
        idle();
        check("b2b_3", {obs_irv, obs_drv}, 2'b10);

        // Reset arriving while a read is in flight
        cycle(1'b1, 32'h600, 1'b1, 4'b0000, 32'h700, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h604, 1'b1, 4'b0000, 32'h704, 32'h0, 1'b0, 1'b1);
        check("rst_mid_read", {obs_ig, obs_dg, obs_irv, obs_drv}, 4'b0000);
        idle();
        check("rst_mid_conflict", bus.conflict_cnt, 32'd0);
        check("rst_mid_rvalid", {obs_irv, obs_drv}, 2'b00);

        // Random traffic, biased toward contention
        for (int i = 0; i < 400; i++) begin
            logic       ir, dr, cc, rst;
            logic [3:0] wen;
            ir  = ($urandom_range(0, 3) != 0);
            dr  = ($urandom_range(0, 3) != 0);
            wen = ($urandom_range(0, 1) != 0) ? 4'b0000 : 4'($urandom);
            cc  = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 59) == 0);
            cycle(ir, $urandom, dr, wen, $urandom, $urandom, cc, rst);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
